// File: rtl/pwm_gen.sv
// PWM generator with prescaled period counter, ramped compare value and a
// four-state status machine (IDLE / RAMP_UP / RUN / RAMP_DOWN).
// The compare value only moves at period boundaries so every PWM period is
// glitch-free; an emergency stop clears the drive immediately.
module pwm_gen #(
    parameter int PRESCALE  = 100,
    parameter int PERIOD    = 100,
    parameter int DUTY1     = 30,
    parameter int DUTY2     = 60,
    parameter int DUTY3     = 90,
    parameter int RAMP_STEP = 5
) (
    input  logic       sysclk,
    input  logic       i_reset,
    input  logic [1:0] i_pwm_duty,
    input  logic       i_stop,
    output logic       o_pwm,
    output logic       o_period_tick,
    output logic       o_busy,
    output logic [1:0] o_state
);

    // Counter widths: cmp must be able to hold PERIOD itself (100 % duty).
    localparam int CW = $clog2(PERIOD + 1);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CW-1:0] PERIOD_M1 = CW'(PERIOD - 1);
    localparam logic [PW-1:0] PRESC_M1  = PW'(PRESCALE - 1);
    localparam logic [31:0]   STEP32    = 32'(RAMP_STEP);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RAMP_UP   = 2'b01,
        ST_RUN       = 2'b10,
        ST_RAMP_DOWN = 2'b11
    } state_e;

    // Map the duty code onto its compare target.
    function automatic logic [CW-1:0] duty_target(input logic [1:0] code);
        logic [CW-1:0] t;
        case (code)
            2'b01:   t = CW'(DUTY1);
            2'b10:   t = CW'(DUTY2);
            2'b11:   t = CW'(DUTY3);
            default: t = {CW{1'b0}};
        endcase
        return t;
    endfunction

    // One ramp step towards the target. Done in 32 bits so cmp+STEP cannot
    // wrap; clamping to the target keeps the result within 0..PERIOD.
    function automatic logic [CW-1:0] ramp_next(input logic [CW-1:0] cur,
                                                input logic [CW-1:0] tgt);
        logic [31:0] c32;
        logic [31:0] t32;
        logic [31:0] r32;
        c32 = 32'(cur);
        t32 = 32'(tgt);
        if (c32 < t32) begin
            if ((t32 - c32) <= STEP32) begin
                r32 = t32;
            end else begin
                r32 = c32 + STEP32;
            end
        end else if (c32 > t32) begin
            if ((c32 - t32) <= STEP32) begin
                r32 = t32;
            end else begin
                r32 = c32 - STEP32;
            end
        end else begin
            r32 = c32;
        end
        return CW'(r32);
    endfunction

    // Status derived from the (already updated) compare value and target.
    function automatic state_e classify(input logic [CW-1:0] cmp,
                                        input logic [CW-1:0] tgt);
        state_e s;
        if ((cmp == {CW{1'b0}}) && (tgt == {CW{1'b0}})) begin
            s = ST_IDLE;
        end else if (cmp < tgt) begin
            s = ST_RAMP_UP;
        end else if (cmp > tgt) begin
            s = ST_RAMP_DOWN;
        end else begin
            s = ST_RUN;
        end
        return s;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cmp_q, cmp_d;
    logic [CW-1:0] target_q, target_d;
    state_e        state_q, state_d;
    logic          pwm_q, pwm_d;
    logic          period_tick_q, period_tick_d;
    logic          busy_q, busy_d;
    logic          tick_s;
    logic          wrap_s;

    assign tick_s = (presc_q == PRESC_M1);
    // Period boundary: the tick on which cnt goes from PERIOD-1 back to 0.
    assign wrap_s = tick_s && (cnt_q == PERIOD_M1);

    // Prescaler and free-running period counter (never paused by stop).
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (tick_s) begin
            presc_d = {PW{1'b0}};
            if (cnt_q == PERIOD_M1) begin
                cnt_d = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + CW'(1'b1);
            end
        end else begin
            presc_d = presc_q + PW'(1'b1);
        end
    end

    // Target capture, compare ramp and state update; stop overrides the ramp.
    always_comb begin
        target_d = duty_target(i_pwm_duty);
        cmp_d    = cmp_q;
        state_d  = state_q;
        if (i_stop) begin
            cmp_d   = {CW{1'b0}};
            state_d = ST_IDLE;
        end else if (wrap_s) begin
            cmp_d   = ramp_next(cmp_q, target_q);
            state_d = classify(cmp_d, target_q);
        end else begin
            cmp_d   = cmp_q;
            state_d = state_q;
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        pwm_d         = (cnt_q < cmp_q);
        busy_d        = (cmp_q != target_q);
        period_tick_d = wrap_s;
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge sysclk) begin
        if (i_reset) begin
            presc_q       <= {PW{1'b0}};
            cnt_q         <= {CW{1'b0}};
            cmp_q         <= {CW{1'b0}};
            target_q      <= {CW{1'b0}};
            state_q       <= ST_IDLE;
            pwm_q         <= 1'b0;
            period_tick_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            cmp_q         <= cmp_d;
            target_q      <= target_d;
            state_q       <= state_d;
            pwm_q         <= pwm_d;
            period_tick_q <= period_tick_d;
            busy_q        <= busy_d;
        end
    end

    assign o_pwm         = pwm_q;
    assign o_period_tick = period_tick_q;
    assign o_busy        = busy_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: directed scenarios plus a random phase,
// all compared every cycle against a time-based reference model.
module tb_pwm_gen;

    localparam int PRESCALE = 2;
    localparam int PERIOD   = 10;
    localparam int D1       = 3;
    localparam int D2       = 6;
    localparam int D3       = 9;
    localparam int STEP     = 2;
    localparam int FRAME    = PRESCALE * PERIOD;

    localparam int S_IDLE = 0;
    localparam int S_UP   = 1;
    localparam int S_RUN  = 2;
    localparam int S_DOWN = 3;

    logic       sysclk;
    logic       rst;
    logic [1:0] duty;
    logic       stop;
    logic       o_pwm;
    logic       o_period_tick;
    logic       o_busy;
    logic [1:0] o_state;

    int checks = 0;
    int errors = 0;

    // Reference model state: m_t is the number of cycles since the last reset edge.
    int m_t, m_cmp, m_tgt, m_state, m_pwm, m_busy, m_ptick;

    pwm_gen #(
        .PRESCALE (PRESCALE),
        .PERIOD   (PERIOD),
        .DUTY1    (D1),
        .DUTY2    (D2),
        .DUTY3    (D3),
        .RAMP_STEP(STEP)
    ) dut (
        .sysclk       (sysclk),
        .i_reset      (rst),
        .i_pwm_duty   (duty),
        .i_stop       (stop),
        .o_pwm        (o_pwm),
        .o_period_tick(o_period_tick),
        .o_busy       (o_busy),
        .o_state      (o_state)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int duty_map(input logic [1:0] c);
        case (c)
            2'b01:   return D1;
            2'b10:   return D2;
            2'b11:   return D3;
            default: return 0;
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs held before it.
    task automatic model_edge();
        int  cnt;
        bit  bnd;
        if (rst) begin
            m_t = 0; m_cmp = 0; m_tgt = 0; m_state = S_IDLE;
            m_pwm = 0; m_busy = 0; m_ptick = 0;
        end else begin
            cnt     = (m_t / PRESCALE) % PERIOD;
            bnd     = ((m_t % FRAME) == FRAME - 1);
            m_pwm   = (cnt < m_cmp) ? 1 : 0;
            m_busy  = (m_cmp != m_tgt) ? 1 : 0;
            m_ptick = bnd ? 1 : 0;
            if (stop) begin
                m_cmp   = 0;
                m_state = S_IDLE;
            end else if (bnd) begin
                if (m_cmp < m_tgt)
                    m_cmp = (m_cmp + STEP < m_tgt) ? m_cmp + STEP : m_tgt;
                else if (m_cmp > m_tgt)
                    m_cmp = (m_cmp - STEP > m_tgt) ? m_cmp - STEP : m_tgt;
                if (m_cmp == 0 && m_tgt == 0) m_state = S_IDLE;
                else if (m_cmp < m_tgt)       m_state = S_UP;
                else if (m_cmp > m_tgt)       m_state = S_DOWN;
                else                          m_state = S_RUN;
            end
            m_tgt = duty_map(duty);
            m_t++;
        end
    endtask

    // One clock: update model at the edge, compare all outputs 1 time unit later.
    task automatic cyc();
        @(posedge sysclk);
        model_edge();
        #1;
        check("pwm",   o_pwm,         m_pwm);
        check("busy",  o_busy,        m_busy);
        check("ptick", o_period_tick, m_ptick);
        check("state", o_state,       m_state);
    endtask

    // Count PWM-high cycles over one full period, ending on the next period tick.
    task automatic window(output int highs);
        highs = 0;
        repeat (FRAME) begin
            cyc();
            if (o_pwm === 1'b1) highs++;
        end
    endtask

    // Bounded wait for the next period tick; returns edges elapsed.
    task automatic wait_ptick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (o_period_tick !== 1'b1 && n < 100);
    endtask

    initial begin
        int n;
        int h;
        int up_h[7]   = '{0, 4, 8, 12, 16, 18, 18};
        int up_s[7]   = '{S_UP, S_UP, S_UP, S_UP, S_RUN, S_RUN, S_RUN};
        int dn_h[4]   = '{18, 14, 10, 6};
        int dn_s[4]   = '{S_DOWN, S_DOWN, S_RUN, S_RUN};

        rst  = 1'b1;
        duty = 2'b11;
        stop = 1'b0;

        // Reset held 3 cycles with a nonzero duty code.
        repeat (3) cyc();
        check("rst_pwm",   o_pwm,         1'b0);
        check("rst_busy",  o_busy,        1'b0);
        check("rst_ptick", o_period_tick, 1'b0);
        check("rst_state", o_state,       2'b00);
        rst  = 1'b0;
        duty = 2'b00;
        wait_ptick(n);
        check("first_ptick_delay", n, 20);

        // Ramp up to DUTY3: 2,4,6,8,9,9.
        duty = 2'b11;
        for (int i = 0; i < 7; i++) begin
            window(h);
            check("up_highs", h, up_h[i]);
            check("up_state", o_state, up_s[i]);
        end
        check("up_busy_low", o_busy, 1'b0);

        // Ramp down to DUTY1: 7,5,3.
        duty = 2'b01;
        for (int i = 0; i < 4; i++) begin
            window(h);
            check("dn_highs", h, dn_h[i]);
            check("dn_state", o_state, dn_s[i]);
        end

        // Up to DUTY2 and hold RUN at 6.
        duty = 2'b10;
        window(h);
        check("d2_highs_a", h, 6);
        check("d2_state_a", o_state, S_UP);
        window(h);
        check("d2_highs_b", h, 10);
        check("d2_state_b", o_state, S_RUN);

        // One-cycle stop pulse inside a RUN period.
        repeat (5) cyc();
        stop = 1'b1;
        cyc();
        check("stop_state", o_state, S_IDLE);
        stop = 1'b0;
        cyc();
        check("stop_pwm_off", o_pwm, 1'b0);
        wait_ptick(n);
        check("stop_cnt_runs", n, 13);
        check("restart_state", o_state, S_UP);
        window(h);
        check("restart_highs_2", h, 4);
        check("restart_state_4", o_state, S_UP);

        // Mid-period duty toggles while cmp=4: current period unchanged.
        h = 0;
        repeat (6) begin cyc(); if (o_pwm === 1'b1) h++; end
        duty = 2'b01;
        repeat (6) begin cyc(); if (o_pwm === 1'b1) h++; end
        duty = 2'b00;
        repeat (8) begin cyc(); if (o_pwm === 1'b1) h++; end
        check("toggle_highs", h, 8);
        check("toggle_redirect", o_state, S_DOWN);
        window(h);
        check("toggle_highs_2", h, 4);
        check("toggle_idle", o_state, S_IDLE);

        // Stop coinciding with a boundary, then reset mid-ramp.
        duty = 2'b11;
        window(h);
        check("sb_highs_0", h, 0);
        check("sb_state_up", o_state, S_UP);
        repeat (FRAME - 1) cyc();
        stop = 1'b1;
        cyc();
        check("sb_ptick", o_period_tick, 1'b1);
        check("sb_state_idle", o_state, S_IDLE);
        stop = 1'b0;
        window(h);
        check("sb_stop_wins", h, 0);
        check("sb_reramp", o_state, S_UP);
        repeat (7) cyc();
        rst = 1'b1;
        repeat (2) cyc();
        check("mr_pwm",   o_pwm,         1'b0);
        check("mr_busy",  o_busy,        1'b0);
        check("mr_ptick", o_period_tick, 1'b0);
        check("mr_state", o_state,       2'b00);
        rst = 1'b0;
        wait_ptick(n);
        check("mr_first_ptick", n, 20);
        check("mr_state_up", o_state, S_UP);

        // Random phase: sparse duty changes, stop pulses and resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 29) == 0) duty = 2'($urandom_range(0, 3));
            stop = ($urandom_range(0, 59) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
